// File: rtl/line_clear_engine_pkg.sv
// Shared board geometry, row type and sequencer state encoding for the line-clear engine.
package line_clear_engine_pkg;

  localparam int BOARD_W = 10;
  localparam int BOARD_H = 20;
  localparam int ROW_AW  = $clog2(BOARD_H);
  localparam int CNT_W   = $clog2(BOARD_H + 1);

  typedef logic [BOARD_W-1:0] row_t;

  localparam row_t ROW_FULL = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_EVAL,
    S_FILL,
    S_DONE
  } lce_state_t;

  function automatic logic row_is_full(input row_t row);
    return (row == ROW_FULL);
  endfunction

endpackage

// File: rtl/line_clear_engine_if.sv
// Board memory port: one row per word, synchronous read with one cycle of latency.
interface line_clear_engine_if;
  import line_clear_engine_pkg::*;

  logic              mem_rd_en;
  logic [ROW_AW-1:0] mem_rd_addr;
  row_t              mem_rd_data;
  logic              mem_wr_en;
  logic [ROW_AW-1:0] mem_wr_addr;
  row_t              mem_wr_data;

  modport master (
    output mem_rd_en,
    output mem_rd_addr,
    input  mem_rd_data,
    output mem_wr_en,
    output mem_wr_addr,
    output mem_wr_data
  );

  modport slave (
    input  mem_rd_en,
    input  mem_rd_addr,
    output mem_rd_data,
    input  mem_wr_en,
    input  mem_wr_addr,
    input  mem_wr_data
  );

endinterface

// File: rtl/line_clear_engine.sv
// Scans the board bottom-up, drops full rows, compacts the rest downward and
// zero-fills the vacated top rows, reporting the number of lines removed.
module line_clear_engine
  import line_clear_engine_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    lines_cleared,
  line_clear_engine_if.master mem
);

  lce_state_t        r_state;
  lce_state_t        w_state_nxt;
  logic [ROW_AW-1:0] r_rd_ptr;
  logic [ROW_AW-1:0] r_wr_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  r_lines_cleared;

  logic              w_row_full;
  logic [CNT_W-1:0]  w_count_eval;
  logic              w_move_row;

  assign w_row_full   = row_is_full(mem.mem_rd_data);
  assign w_count_eval = r_count + CNT_W'(w_row_full);
  // A surviving row is only rewritten once something below it has been removed.
  assign w_move_row   = !w_row_full && (r_wr_ptr != r_rd_ptr);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (start) w_state_nxt = S_READ;
      S_READ: w_state_nxt = S_EVAL;
      S_EVAL: begin
        if (r_rd_ptr != '0)          w_state_nxt = S_READ;
        else if (w_count_eval != '0) w_state_nxt = S_FILL;
        else                         w_state_nxt = S_DONE;
      end
      S_FILL: if (r_wr_ptr == '0) w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr        <= '0;
      r_wr_ptr        <= '0;
      r_count         <= '0;
      r_lines_cleared <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_rd_ptr <= ROW_AW'(BOARD_H - 1);
            r_wr_ptr <= ROW_AW'(BOARD_H - 1);
            r_count  <= '0;
          end
        end
        S_EVAL: begin
          r_count <= w_count_eval;
          if (!w_row_full && (r_wr_ptr != '0)) r_wr_ptr <= r_wr_ptr - 1'b1;
          if (r_rd_ptr != '0)                  r_rd_ptr <= r_rd_ptr - 1'b1;
        end
        S_FILL: begin
          if (r_wr_ptr != '0) r_wr_ptr <= r_wr_ptr - 1'b1;
        end
        S_DONE: r_lines_cleared <= r_count;
        default: ;
      endcase
    end
  end

  always_comb begin
    busy            = (r_state != S_IDLE);
    done            = 1'b0;
    mem.mem_rd_en   = 1'b0;
    mem.mem_rd_addr = '0;
    mem.mem_wr_en   = 1'b0;
    mem.mem_wr_addr = '0;
    mem.mem_wr_data = '0;
    case (r_state)
      S_READ: begin
        mem.mem_rd_en   = 1'b1;
        mem.mem_rd_addr = r_rd_ptr;
      end
      S_EVAL: begin
        if (w_move_row) begin
          mem.mem_wr_en   = 1'b1;
          mem.mem_wr_addr = r_wr_ptr;
          mem.mem_wr_data = mem.mem_rd_data;
        end
      end
      S_FILL: begin
        mem.mem_wr_en   = 1'b1;
        mem.mem_wr_addr = r_wr_ptr;
      end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign lines_cleared = r_lines_cleared;

endmodule
